// File: rtl/multibyte_add_sequencer.sv
// Sequences an NBYTES-wide add through an external registered 8-bit adder,
// LSB first, chaining the carry byte to byte; valid/ready on both sides.
module multibyte_add_sequencer #(
  parameter int NBYTES  = 4,
  parameter int ADD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_a,
  input  logic [8*NBYTES-1:0]   in_b,
  input  logic                  in_cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_sum,
  output logic                  out_cout,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_sum,
  input  logic                  add_cout
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CW = $clog2(ADD_LAT + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NBYTES - 1);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(ADD_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_DONE} state_e;

  state_e state_q, state_d;

  logic [NBYTES-1:0][7:0] a_q, a_d, b_q, b_d, acc_q, acc_d, out_sum_q, out_sum_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   carry_q, carry_d;
  logic [7:0]             add_a_q, add_a_d, add_b_q, add_b_d;
  logic                   add_cin_q, add_cin_d;
  logic                   out_cout_q, out_cout_d;
  logic                   in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (in_valid && in_ready_q) state_d = S_ISSUE;
      S_ISSUE:   state_d = (ADD_LAT > 1) ? S_WAIT : S_CAPTURE;
      S_WAIT:    if (cnt_q == CW'(1)) state_d = S_CAPTURE;
      S_CAPTURE: state_d = (idx_q == LAST_IDX) ? S_DONE : S_ISSUE;
      S_DONE:    if (out_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    add_cin_d  = add_cin_q;
    out_sum_d  = out_sum_q;
    out_cout_d = out_cout_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      S_ISSUE: begin
        add_a_d   = a_q[idx_q];
        add_b_d   = b_q[idx_q];
        add_cin_d = carry_q;
        cnt_d     = WAIT_LOAD;
      end
      S_WAIT: cnt_d = cnt_q - 1'b1;
      S_CAPTURE: begin
        acc_d[idx_q] = add_sum;
        carry_d      = add_cout;
        if (idx_q == LAST_IDX) begin
          out_sum_d  = acc_d;
          out_cout_d = add_cout;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: ;
    endcase
    // Handshake flags are decoded from the next state so both stay registered.
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Bench: directed cases on a 4-byte/lat-2 instance, then random streams on
// that instance and a 1-byte/lat-1 instance against an A+B+cin scoreboard.
module tb_multibyte_add_sequencer;
  localparam int NREQ = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout;
  logic [31:0] in_a, in_b, out_sum;
  logic [7:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  logic        in_valid1, in_ready1, in_cin1, out_valid1, out_ready1, out_cout1;
  logic [7:0]  in_a1, in_b1, out_sum1;
  logic [7:0]  add_a1, add_b1, add_sum1;
  logic        add_cin1, add_cout1;

  multibyte_add_sequencer #(.NBYTES(4), .ADD_LAT(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout));

  multibyte_add_sequencer #(.NBYTES(1), .ADD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_sum(out_sum1), .out_cout(out_cout1),
    .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
    .add_sum(add_sum1), .add_cout(add_cout1));

  // Adder models: one register stage for latency 2, combinational for latency 1.
  logic [8:0] sum0_r;
  always @(posedge clk) begin
    if (rst) sum0_r <= '0;
    else     sum0_r <= {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};
  end
  assign {add_cout, add_sum}   = sum0_r;
  assign {add_cout1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1} + {8'b0, add_cin1};

  int n_chk = 0;
  int n_err = 0;
  logic cin_log[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  // Called #1 after a rising edge; returns the cycle in which out_valid is first seen.
  task automatic do_req(input logic [31:0] a, input logic [31:0] b, input logic c, output int lat);
    int n;
    n = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = c;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    cin_log.delete();
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (lat >= 2 && (lat - 2) % 3 == 0) cin_log.push_back(add_cin);
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("rel_in_ready", 64'(in_ready), 1);
    chk("rel_out_valid", 64'(out_valid), 0);
  endtask

  initial begin
    int lat;
    logic [32:0] exp;
    logic [3:0] cins;
    in_valid = 0; in_a = 0; in_b = 0; in_cin = 0; out_ready = 0;
    in_valid1 = 0; in_a1 = 0; in_b1 = 0; in_cin1 = 0; out_ready1 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_sum", 64'(out_sum), 0);
    chk("rst_out_cout", 64'(out_cout), 0);
    chk("rst_add", {add_a, add_b, 7'b0, add_cin}, 0);
    chk("rst_in_ready1", 64'(in_ready1), 1);
    rst = 1'b0;
    @(posedge clk); #1;

    do_req(32'hFFFF_FFFF, 32'h1, 1'b0, lat);
    chk("wrap_lat", 64'(lat), 13);
    chk("wrap_sum", 64'(out_sum), 0);
    chk("wrap_cout", 64'(out_cout), 1);
    release_result();

    do_req(32'h1234_5678, 32'h1111_1111, 1'b1, lat);
    chk("cin_sum", 64'(out_sum), 64'h2345_678A);
    chk("cin_cout", 64'(out_cout), 0);
    release_result();

    do_req(32'h00FF_00FF, 32'h0001_0001, 1'b0, lat);
    cins = '0;
    for (int i = 0; i < 4 && i < cin_log.size(); i++) cins[i] = cin_log[i];
    chk("chain_nissue", 64'(cin_log.size()), 4);
    chk("chain_add_cin", 64'(cins), 64'b1010);
    chk("chain_sum", 64'(out_sum), 64'h0100_0100);
    chk("chain_cout", 64'(out_cout), 0);
    release_result();

    // Backpressure: result held, in_valid pulse ignored while DONE.
    in_a = pick(); in_b = pick(); in_cin = 1'($urandom_range(0, 1));
    exp = 33'(in_a) + 33'(in_b) + 33'(in_cin);
    do_req(in_a, in_b, in_cin, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = (i == 1 || i == 2);
      in_a = 32'hDEAD_BEEF; in_b = 32'h1;
      chk("bp_result", {out_cout, out_sum}, exp);
      chk("bp_in_ready", 64'(in_ready), 0);
      chk("bp_out_valid", 64'(out_valid), 1);
    end
    in_valid = 1'b0;
    release_result();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_idle", 64'(in_ready), 1);
    end
    chk("bp_hold", {out_cout, out_sum}, exp);

    // Reset asserted in cycle 5 of an operation.
    in_valid = 1'b1; in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF; in_cin = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy", {add_a, add_b}, 16'hFFFF);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_in_ready", 64'(in_ready), 1);
    chk("mid_out_valid", 64'(out_valid), 0);
    chk("mid_out", {out_cout, out_sum}, 0);
    chk("mid_add", {add_a, add_b, 7'b0, add_cin}, 0);
    do_req(32'h2, 32'h3, 1'b0, lat);
    chk("mid_lat", 64'(lat), 13);
    chk("mid_follow", {out_cout, out_sum}, 64'h5);
    release_result();

    fork
      begin : rnd0
        logic [32:0] q0[$];
        int acc, got, cyc;
        acc = 0; got = 0; cyc = 0;
        while (got < NREQ && cyc < 30000) begin
          @(posedge clk); #1;
          cyc++;
          in_valid  = (acc < NREQ) && ($urandom_range(0, 3) != 0);
          in_a      = pick();
          in_b      = pick();
          in_cin    = 1'($urandom_range(0, 1));
          out_ready = ($urandom_range(0, 2) != 0);
          @(negedge clk);
          if (in_valid && in_ready) begin
            q0.push_back(33'(in_a) + 33'(in_b) + 33'(in_cin));
            acc++;
          end
          if (out_valid && out_ready) begin
            if (q0.size() == 0) chk("rnd0_extra", 64'(q0.size()), 1);
            else chk("rnd0_result", {out_cout, out_sum}, q0.pop_front());
            got++;
          end
        end
        chk("rnd0_count", 64'(got), NREQ);
        chk("rnd0_left", 64'(q0.size()), 0);
      end
      begin : rnd1
        logic [8:0] q1[$];
        logic [31:0] r;
        int acc, got, cyc;
        acc = 0; got = 0; cyc = 0;
        while (got < NREQ && cyc < 30000) begin
          @(posedge clk); #1;
          cyc++;
          in_valid1  = (acc < NREQ) && ($urandom_range(0, 3) != 0);
          r          = pick();
          in_a1      = r[7:0];
          in_b1      = r[15:8];
          in_cin1    = 1'($urandom_range(0, 1));
          out_ready1 = ($urandom_range(0, 2) != 0);
          @(negedge clk);
          if (in_valid1 && in_ready1) begin
            q1.push_back(9'(in_a1) + 9'(in_b1) + 9'(in_cin1));
            acc++;
          end
          if (out_valid1 && out_ready1) begin
            if (q1.size() == 0) chk("rnd1_extra", 64'(q1.size()), 1);
            else chk("rnd1_result", {out_cout1, out_sum1}, q1.pop_front());
            got++;
          end
        end
        chk("rnd1_count", 64'(got), NREQ);
        chk("rnd1_left", 64'(q1.size()), 0);
      end
    join

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/multibyte_add_sequencer.md
# multibyte_add_sequencer

Multi-byte add controller that performs an NBYTES-wide addition by driving the team's registered 8-bit ripple-carry adder one byte at a time, LSB first, and chaining the carry between bytes. It sits directly upstream of the adder, feeding its `a`/`b`/`cin` inputs, and consumes the adder's registered `sum`/`cout` outputs. It presents a valid/ready operand interface to the datapath and a valid/ready result interface.

## Interface
- `NBYTES`, default 4: operand width in bytes; must be ≥ 1.
- `ADD_LAT`, default 2: cycles from driving the adder inputs until `add_sum`/`add_cout` are valid; must be ≥ 1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, **synchronous, active-high**.
- `in_valid` in 1: operand request valid.
- `in_ready` out 1: block can accept an operand request.
- `in_a` in 8*NBYTES: operand A.
- `in_b` in 8*NBYTES: operand B.
- `in_cin` in 1: carry-in to byte 0.
- `out_valid` out 1: result valid.
- `out_ready` in 1: result consumer ready.
- `out_sum` out 8*NBYTES: sum.
- `out_cout` out 1: carry-out of the most significant byte.
- `add_a` out 8: byte of A driven to the adder.
- `add_b` out 8: byte of B driven to the adder.
- `add_cin` out 1: carry driven to the adder.
- `add_sum` in 8: adder sum.
- `add_cout` in 1: adder carry-out.

## Operation
- States: IDLE, ISSUE, WAIT, CAPTURE, DONE.
- **Reset values:** state=IDLE; `in_ready`=1; `out_valid`=0; `out_sum`=0; `out_cout`=0; `add_a`/`add_b`/`add_cin`=0; byte index=0; wait counter=0; carry register=0.
- **IDLE:** `in_ready`=1.
  - On `in_valid && in_ready`, latch `in_a`, `in_b` and `in_cin` (the carry register takes `in_cin`), clear the byte index and accumulator, then go to ISSUE.
  - Inputs are ignored in every state other than IDLE.
- **ISSUE:** register `add_a` = A[8k+7:8k], `add_b` = B[8k+7:8k] and `add_cin` = carry register, where k is the byte index. Load the wait counter with ADD_LAT−1.
  - Go to WAIT if ADD_LAT > 1; otherwise go to CAPTURE.
- **Adder input hold:** `add_a`/`add_b`/`add_cin` hold their values until the next ISSUE. They return to 0 only on reset.
- **WAIT:** decrement the wait counter. When the counter reaches 1, the next state is CAPTURE.
- **CAPTURE:** write `add_sum` into accumulator byte k and `add_cout` into the carry register.
  - If k = NBYTES−1: `out_sum` ← accumulator (including this byte), `out_cout` ← `add_cout`, go to DONE.
  - Otherwise: k ← k+1, go to ISSUE.
- **DONE:** `out_valid`=1; `out_sum`/`out_cout` are held stable.
  - On `out_ready`, go to IDLE and `out_valid` deasserts on the next cycle.
  - `in_ready`=0 while in DONE (no overlap of results and new requests).
- **Arithmetic:** result is `{out_cout, out_sum}` = A + B + `in_cin`, modulo 2^(8*NBYTES+1). Overflow appears only in `out_cout`.
- **Reset mid-operation:** abort immediately. All outputs take their reset values on the next edge and any partial result is discarded. Adder output values seen after reset are ignored until the next ISSUE.

## Timing
- Cycle 0 is the accept cycle (`in_valid && in_ready` sampled high at the edge ending cycle 0).
- Byte k ISSUE occurs in cycle 1 + k·(ADD_LAT+1).
- The adder inputs for byte k are visible from the following cycle; the matching CAPTURE is in cycle (k+1)·(ADD_LAT+1).
- `out_valid` rises in cycle NBYTES·(ADD_LAT+1) + 1; this is cycle 13 for the defaults.
- A result handshake in cycle t gives `in_ready`=1 in cycle t+1. The minimum request-to-request interval for the defaults is 14 cycles.
- `in_ready` and `out_valid` are mutually exclusive and both are registered; no combinational path from inputs to outputs.
- Parent ties the adder's `clk`/`rst` to this block's `clk`/`rst`.

## Test plan
- **Wrap-around:** A=0xFFFFFFFF, B=0x00000001, `in_cin`=0 → `out_sum`=0x00000000, `out_cout`=1, `out_valid` first seen in cycle 13.
- **Carry-in:** A=0x12345678, B=0x11111111, `in_cin`=1 → `out_sum`=0x2345678A, `out_cout`=0.
- **Carry chaining:** A=0x00FF00FF, B=0x00010001, `in_cin`=0 → `add_cin` on the four ISSUE cycles is 0,1,0,1; `out_sum`=0x01000100, `out_cout`=0.
- **Backpressure:** hold `out_ready`=0 for 5 cycles after `out_valid` rises → `out_sum`/`out_cout` stable, `in_ready`=0, and a `in_valid` pulse in that window is ignored. Release → `in_ready`=1 one cycle later.
- **Reset mid-op:** assert `rst` in cycle 5 of an A=0xFFFFFFFF, B=0xFFFFFFFF add → next cycle all outputs at reset values and `in_ready`=1. A follow-up request A=0x00000002, B=0x00000003, `in_cin`=0 gives 0x00000005 with `out_cout`=0.
- **Back-to-back with self-check:** back-to-back random requests (≥200), with `in_valid`/`out_ready` randomly toggled → every result matches the reference A+B+cin, with no drops or duplicates. Also run with NBYTES=1 and ADD_LAT=1.
